// File: rtl/tag_lookup_controller_if.sv
// Bundle of signals between the tag lookup controller and its surroundings
// (requester, tag units, tag write path, responder).
//   master : the controller side (drives lookup/write strobes and responses)
//   slave  : the environment side (drives requests, tag-unit results, responseReady)
// Signals:
//   requestValid/requestReady/requestIndex/requestTag  - lookup request handshake
//   lookupEnable/lookupIndex/lookupTag                 - strobe to the tag units
//   hitVector/validVector                              - per-way results from tag units
//   writeEnable/cacheNumberIn                          - tag write strobe and way select
//   responseValid/responseReady/responseHit/
//   cacheNumberOut/multiHit                            - lookup result handshake
interface tag_lookup_controller_if #(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int SET_ASSOCIATIVITY = 2
);
  localparam int WAYS = 2 ** SET_ASSOCIATIVITY;

  logic                         requestValid;
  logic                         requestReady;
  logic [INDEX_WIDTH-1:0]       requestIndex;
  logic [TAG_WIDTH-1:0]         requestTag;

  logic                         lookupEnable;
  logic [INDEX_WIDTH-1:0]       lookupIndex;
  logic [TAG_WIDTH-1:0]         lookupTag;

  logic [WAYS-1:0]              hitVector;
  logic [WAYS-1:0]              validVector;

  logic                         writeEnable;
  logic [SET_ASSOCIATIVITY-1:0] cacheNumberIn;

  logic                         responseValid;
  logic                         responseReady;
  logic                         responseHit;
  logic [SET_ASSOCIATIVITY-1:0] cacheNumberOut;
  logic                         multiHit;

  modport master (
    input  requestValid, requestIndex, requestTag,
    input  hitVector, validVector, responseReady,
    output requestReady, lookupEnable, lookupIndex, lookupTag,
    output writeEnable, cacheNumberIn,
    output responseValid, responseHit, cacheNumberOut, multiHit
  );

  modport slave (
    output requestValid, requestIndex, requestTag,
    output hitVector, validVector, responseReady,
    input  requestReady, lookupEnable, lookupIndex, lookupTag,
    input  writeEnable, cacheNumberIn,
    input  responseValid, responseHit, cacheNumberOut, multiHit
  );
endinterface

// File: rtl/tag_lookup_controller.sv
// Tag lookup controller for a set-associative tag store.
// Accepts one lookup request at a time, strobes the tag units, evaluates the
// per-way hit/valid results, allocates a way on a miss (lowest invalid way,
// otherwise a per-set round-robin victim pointer), and returns the hit/way
// result through a valid/ready response handshake.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - tag_lookup_controller_if.master (request, lookup, write, response)
module tag_lookup_controller #(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int SET_ASSOCIATIVITY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  tag_lookup_controller_if.master bus
);

  localparam int WAYS = 2 ** SET_ASSOCIATIVITY;
  localparam int SETS = 2 ** INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    ALLOCATE,
    RESPOND
  } stateType;

  stateType                                 state;
  logic [SETS-1:0][SET_ASSOCIATIVITY-1:0]   victimPointer;

  logic                                     lookupEnableReg;
  logic [INDEX_WIDTH-1:0]                   lookupIndexReg;
  logic [TAG_WIDTH-1:0]                     lookupTagReg;
  logic                                     writeEnableReg;
  logic [SET_ASSOCIATIVITY-1:0]             cacheNumberInReg;
  logic                                     responseValidReg;
  logic                                     responseHitReg;
  logic [SET_ASSOCIATIVITY-1:0]             cacheNumberOutReg;
  logic                                     multiHitReg;

  logic                                     allValid;
  logic [SET_ASSOCIATIVITY-1:0]             allocWay;

  function automatic logic [SET_ASSOCIATIVITY-1:0] lowestSetBit(input logic [WAYS-1:0] vec);
    logic [SET_ASSOCIATIVITY-1:0] way;
    way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) way = SET_ASSOCIATIVITY'(i);
    end
    return way;
  endfunction

  function automatic logic moreThanOne(input logic [WAYS-1:0] vec);
    int count;
    count = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (vec[i]) count++;
    end
    return (count > 1);
  endfunction

  // Victim choice for a miss: prefer a free way; only a full set consumes
  // the round-robin pointer.
  always_comb begin
    allValid = &bus.validVector;
    allocWay = lowestSetBit(~bus.validVector);
    if (allValid) allocWay = victimPointer[lookupIndexReg];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      victimPointer     <= '0;
      lookupEnableReg   <= 1'b0;
      lookupIndexReg    <= '0;
      lookupTagReg      <= '0;
      writeEnableReg    <= 1'b0;
      cacheNumberInReg  <= '0;
      responseValidReg  <= 1'b0;
      responseHitReg    <= 1'b0;
      cacheNumberOutReg <= '0;
      multiHitReg       <= 1'b0;
    end else begin
      case (state)
        // Accept a request; the lookup strobe is raised for the LOOKUP cycle.
        IDLE: begin
          if (bus.requestValid) begin
            lookupIndexReg  <= bus.requestIndex;
            lookupTagReg    <= bus.requestTag;
            lookupEnableReg <= 1'b1;
            state           <= LOOKUP;
          end
        end
        // Tag units see the strobe this cycle and answer in the next one.
        LOOKUP: begin
          lookupEnableReg <= 1'b0;
          state           <= COMPARE;
        end
        // The miss decision is made here so that writeEnable is already a
        // registered pulse throughout ALLOCATE.
        COMPARE: begin
          if (|bus.hitVector) begin
            responseHitReg    <= 1'b1;
            cacheNumberOutReg <= lowestSetBit(bus.hitVector);
            multiHitReg       <= moreThanOne(bus.hitVector);
            responseValidReg  <= 1'b1;
            state             <= RESPOND;
          end else begin
            responseHitReg    <= 1'b0;
            multiHitReg       <= 1'b0;
            cacheNumberOutReg <= allocWay;
            cacheNumberInReg  <= allocWay;
            writeEnableReg    <= 1'b1;
            if (allValid) begin
              victimPointer[lookupIndexReg] <=
                victimPointer[lookupIndexReg] + SET_ASSOCIATIVITY'(1);
            end
            state             <= ALLOCATE;
          end
        end
        // Write strobe cycle; index/tag stay on lookupIndex/lookupTag.
        ALLOCATE: begin
          writeEnableReg   <= 1'b0;
          responseValidReg <= 1'b1;
          state            <= RESPOND;
        end
        // Hold the result until the consumer takes it.
        RESPOND: begin
          if (bus.responseReady) begin
            responseValidReg <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.requestReady   = (state == IDLE);
  assign bus.lookupEnable   = lookupEnableReg;
  assign bus.lookupIndex    = lookupIndexReg;
  assign bus.lookupTag      = lookupTagReg;
  assign bus.writeEnable    = writeEnableReg;
  assign bus.cacheNumberIn  = cacheNumberInReg;
  assign bus.responseValid  = responseValidReg;
  assign bus.responseHit    = responseHitReg;
  assign bus.cacheNumberOut = cacheNumberOutReg;
  assign bus.multiHit       = multiHitReg;

endmodule

// File: tb/tb_tag_lookup_controller.sv
module tb_tag_lookup_controller;

  localparam int TW   = 6;
  localparam int IW   = 6;
  localparam int SA   = 2;
  localparam int WAYS = 4;

  logic clock;
  logic reset;

  int total;
  int bad;
  int refPtr [64];

  tag_lookup_controller_if #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .SET_ASSOCIATIVITY(SA)) bus ();

  tag_lookup_controller #(
    .TAG_WIDTH(TW),
    .INDEX_WIDTH(IW),
    .SET_ASSOCIATIVITY(SA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // index of lowest set bit, via isolating it arithmetically
  function automatic int lowestOne(input int v);
    int iso;
    iso = v & (-v);
    return $clog2(iso);
  endfunction

  task automatic driveNoise();
    bus.hitVector   = WAYS'($urandom);
    bus.validVector = WAYS'($urandom);
  endtask

  // One full request/response transaction, called at a negedge while IDLE.
  task automatic runLookup(input int idx, input int tag, input int hv, input int vv,
                           input int stall, output int gotWay);
    int  expWay;
    int  expHit;
    int  expMulti;
    if (hv != 0) begin
      expHit   = 1;
      expWay   = lowestOne(hv);
      expMulti = ($countones(hv) > 1) ? 1 : 0;
    end else begin
      expHit   = 0;
      expMulti = 0;
      if (vv == 15) begin
        expWay      = refPtr[idx];
        refPtr[idx] = (refPtr[idx] + 1) % WAYS;
      end else begin
        expWay = lowestOne((~vv) & 15);
      end
    end

    checkValue("requestReadyIdle", int'(bus.requestReady), 1);
    bus.requestValid = 1'b1;
    bus.requestIndex = IW'(idx);
    bus.requestTag   = TW'(tag);
    @(posedge clock); #1;
    bus.requestValid = 1'b0;
    bus.requestIndex = IW'($urandom);
    bus.requestTag   = TW'($urandom);
    driveNoise();

    @(negedge clock);
    checkValue("lookupEnableOn", int'(bus.lookupEnable), 1);
    checkValue("lookupIndex", int'(bus.lookupIndex), idx);
    checkValue("lookupTag", int'(bus.lookupTag), tag);
    checkValue("requestReadyBusy", int'(bus.requestReady), 0);
    checkValue("respValidLookup", int'(bus.responseValid), 0);

    @(posedge clock); #1;
    bus.hitVector   = WAYS'(hv);
    bus.validVector = WAYS'(vv);
    @(negedge clock);
    checkValue("lookupEnableOff", int'(bus.lookupEnable), 0);
    checkValue("respValidCompare", int'(bus.responseValid), 0);
    checkValue("writeEnCompare", int'(bus.writeEnable), 0);

    if (expHit == 0) begin
      @(negedge clock);
      checkValue("writeEnAlloc", int'(bus.writeEnable), 1);
      checkValue("cacheNumberIn", int'(bus.cacheNumberIn), expWay);
      checkValue("cacheNumberOutAlloc", int'(bus.cacheNumberOut), expWay);
      checkValue("lookupIndexHeld", int'(bus.lookupIndex), idx);
      checkValue("lookupTagHeld", int'(bus.lookupTag), tag);
      checkValue("respValidAlloc", int'(bus.responseValid), 0);
    end

    @(posedge clock); #1;
    driveNoise();
    @(negedge clock);
    checkValue("respValid", int'(bus.responseValid), 1);
    checkValue("respHit", int'(bus.responseHit), expHit);
    checkValue("respWay", int'(bus.cacheNumberOut), expWay);
    checkValue("respMulti", int'(bus.multiHit), expMulti);
    checkValue("writeEnRespond", int'(bus.writeEnable), 0);
    gotWay = int'(bus.cacheNumberOut);

    for (int s = 0; s < stall; s++) begin
      bus.requestValid = 1'b1;
      bus.requestIndex = IW'($urandom);
      bus.requestTag   = TW'($urandom);
      @(negedge clock);
      checkValue("stallValid", int'(bus.responseValid), 1);
      checkValue("stallHit", int'(bus.responseHit), expHit);
      checkValue("stallWay", int'(bus.cacheNumberOut), expWay);
      checkValue("stallMulti", int'(bus.multiHit), expMulti);
      checkValue("stallReqReady", int'(bus.requestReady), 0);
      checkValue("stallLookupEn", int'(bus.lookupEnable), 0);
    end

    bus.responseReady = 1'b1;
    @(posedge clock); #1;
    bus.responseReady = 1'b0;
    bus.requestValid  = 1'b0;
    @(negedge clock);
    checkValue("afterHsValid", int'(bus.responseValid), 0);
    checkValue("afterHsReqReady", int'(bus.requestReady), 1);
    checkValue("afterHsLookupEn", int'(bus.lookupEnable), 0);
  endtask

  task automatic checkResetOutputs(input string where);
    checkValue({where, "_state"}, int'(bus.requestReady), 1);
    checkValue({where, "_lookupEn"}, int'(bus.lookupEnable), 0);
    checkValue({where, "_writeEn"}, int'(bus.writeEnable), 0);
    checkValue({where, "_respValid"}, int'(bus.responseValid), 0);
    checkValue({where, "_respHit"}, int'(bus.responseHit), 0);
    checkValue({where, "_multiHit"}, int'(bus.multiHit), 0);
    checkValue({where, "_cacheIn"}, int'(bus.cacheNumberIn), 0);
    checkValue({where, "_cacheOut"}, int'(bus.cacheNumberOut), 0);
    checkValue({where, "_lookupIdx"}, int'(bus.lookupIndex), 0);
    checkValue({where, "_lookupTag"}, int'(bus.lookupTag), 0);
  endtask

  initial begin
    int w;
    total = 0;
    bad   = 0;
    foreach (refPtr[i]) refPtr[i] = 0;
    bus.requestValid  = 1'b0;
    bus.requestIndex  = '0;
    bus.requestTag    = '0;
    bus.hitVector     = '0;
    bus.validVector   = '0;
    bus.responseReady = 1'b0;

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checkResetOutputs("initReset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkValue("readyAfterRelease", int'(bus.requestReady), 1);

    // single hit
    runLookup(5, 'h2A, 4'b0100, 4'b1111, 0, w);
    checkValue("hitWay", w, 2);

    // miss with free ways, then a full miss shows the pointer untouched
    runLookup(7, 'h11, 4'b0000, 4'b0011, 0, w);
    checkValue("freeWay", w, 2);
    runLookup(7, 'h12, 4'b0000, 4'b1111, 0, w);
    checkValue("ptr7Untouched", w, 0);

    // round-robin wrap on a full set
    for (int k = 0; k < 5; k++) begin
      runLookup(9, 'h20 + k, 4'b0000, 4'b1111, 0, w);
      checkValue("wrapWay", w, k % 4);
    end
    runLookup(3, 'h05, 4'b0000, 4'b1111, 0, w);
    checkValue("ptr3Independent", w, 0);

    // multi-hit
    runLookup(2, 'h3F, 4'b1010, 4'b1111, 0, w);
    checkValue("multiHitWay", w, 1);

    // backpressure with ignored requests
    runLookup(4, 'h15, 4'b0001, 4'b1111, 5, w);
    checkValue("bpWay", w, 0);

    // reset while in ALLOCATE
    bus.requestValid = 1'b1;
    bus.requestIndex = IW'(9);
    bus.requestTag   = TW'('h33);
    @(posedge clock); #1;
    bus.requestValid = 1'b0;
    @(posedge clock); #1;
    bus.hitVector   = '0;
    bus.validVector = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    checkValue("writeEnBeforeReset", int'(bus.writeEnable), 1);
    #1 reset = 1'b0;
    #1;
    checkResetOutputs("midReset");
    foreach (refPtr[i]) refPtr[i] = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkValue("readyAfterMidReset", int'(bus.requestReady), 1);
    checkValue("noWriteAfterReset", int'(bus.writeEnable), 0);
    runLookup(9, 'h34, 4'b0000, 4'b1111, 0, w);
    checkValue("ptr9Cleared", w, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      int idx;
      int hv;
      int vv;
      idx = $urandom_range(0, 3);
      hv  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      vv  = ($urandom_range(0, 2) != 0) ? 15 : $urandom_range(0, 15);
      runLookup(idx, $urandom_range(0, 63), hv, vv, $urandom_range(0, 3), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_lookup_controller.md
TAG_LOOKUP_CONTROLLER -- requirements
Module: tag_lookup_controller

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 6, tag bits per lookup.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, set index bits.
REQ-003 SHALL have parameter SET_ASSOCIATIVITY, default 2, log2 of way count (WAYS = 2**SET_ASSOCIATIVITY).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have requestValid  in  1  lookup request; requestReady  out  1  controller idle.
REQ-006 SHALL have requestIndex  in  INDEX_WIDTH  set index; requestTag  in  TAG_WIDTH  tag.
REQ-007 SHALL have lookupEnable  out  1  strobe to tag units; lookupIndex  out  INDEX_WIDTH; lookupTag  out  TAG_WIDTH.
REQ-008 SHALL have hitVector  in  WAYS  per-way tag match (valid and equal); validVector  in  WAYS  per-way valid bits.
REQ-009 SHALL have writeEnable  out  1  tag write strobe; cacheNumberIn  out  SET_ASSOCIATIVITY  way select for the write demultiplexer.
REQ-010 SHALL have responseValid  out  1; responseReady  in  1; responseHit  out  1; cacheNumberOut  out  SET_ASSOCIATIVITY  hit or allocated way; multiHit  out  1  more than one hitVector bit set.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, COMPARE, ALLOCATE, RESPOND.
REQ-012 SHALL assert requestReady only in IDLE; request accepted when requestValid && requestReady, index and tag latched, IDLE->LOOKUP.
REQ-013 SHALL in LOOKUP drive lookupEnable=1 for exactly one cycle with latched index/tag on lookupIndex/lookupTag, then go to COMPARE.
REQ-014 SHALL in COMPARE sample hitVector and validVector (tag units respond one cycle after lookupEnable).
REQ-015 SHALL on any hitVector bit set: responseHit=1, cacheNumberOut=lowest set bit index, multiHit=1 if popcount>1, COMPARE->RESPOND.
REQ-016 SHALL on hitVector=0: COMPARE->ALLOCATE, responseHit=0.
REQ-017 SHALL in ALLOCATE, if any validVector bit is 0, select lowest invalid way and leave victim pointer unchanged.
REQ-018 SHALL in ALLOCATE, if validVector all ones, select victimPointer[index] and increment it modulo WAYS (WAYS-1 wraps to 0).
REQ-019 SHALL in ALLOCATE drive writeEnable=1 for one cycle with cacheNumberIn=selected way, lookupIndex/lookupTag held, cacheNumberOut=selected way, then go to RESPOND.
REQ-020 SHALL keep one victim pointer per set (2**INDEX_WIDTH entries of SET_ASSOCIATIVITY bits); hits never modify pointers.
REQ-021 SHALL in RESPOND hold responseValid=1 and responseHit/cacheNumberOut/multiHit stable until responseReady=1, then return to IDLE.
REQ-022 SHALL give latency accept->responseValid of 3 cycles on hit, 4 cycles on miss; back-to-back minimum: next request accepted the cycle after response handshake.
REQ-023 SHALL ignore requestValid and input data outside IDLE; hitVector/validVector ignored outside COMPARE/ALLOCATE.
REQ-024 SHALL register all outputs except requestReady, which is decoded from state.

Reset
REQ-025 SHALL on reset=0, asynchronously: state=IDLE, all victim pointers=0, lookupEnable=0, writeEnable=0, responseValid=0, responseHit=0, multiHit=0, cacheNumberIn=0, cacheNumberOut=0, lookupIndex=0, lookupTag=0.
REQ-026 SHALL drop an in-flight request on reset mid-operation with no write strobe issued; requestReady=1 on first clock after reset release.

Verification
REQ-027 Hit: request index 5 tag 0x2A, hitVector=0100 in COMPARE -> responseValid cycle 3, responseHit=1, cacheNumberOut=2, no writeEnable.
REQ-028 Miss with free way: index 7, hitVector=0000, validVector=0011 -> writeEnable one cycle with cacheNumberIn=2, response cycle 4, responseHit=0, cacheNumberOut=2, pointer[7] stays 0.
REQ-029 Full-set wrap: five misses to index 9 with validVector=1111 -> allocated ways 0,1,2,3,0; pointer[3] unaffected.
REQ-030 Multi-hit: hitVector=1010 -> cacheNumberOut=1, responseHit=1, multiHit=1.
REQ-031 Backpressure: responseReady held 0 for 5 cycles -> response outputs stable, requestReady=0, new requestValid ignored; accepted cycle after handshake.
REQ-032 Reset in ALLOCATE cycle -> writeEnable=0 immediately, all outputs at reset values, requestReady=1 after release.
